grid_mem_arbiter: RTL

GRID_MEM_ARBITER -- requirements
Module: grid_mem_arbiter

---
 rtl/astar_pkg.sv | 22 ++
 rtl/grid_mem_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/astar_pkg.sv
// Shared A* grid memory types: owner encoding, cell codes, width defaults.
// Imported by grid_mem_arbiter.
package astar_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 2;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_DISP = 2'b01,
    OWN_SRCH = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    CELL_FREE = 2'b00,
    CELL_OBST = 2'b01,
    CELL_PATH = 2'b10,
    CELL_UNKN = 2'b11
  } cell_e;

endpackage

// File: rtl/grid_mem_arbiter.sv
// Single-port grid memory arbiter: display vs search, display priority.
// Ports: sync/reset; s_* search req/gnt/read return; d_* display req/gnt/
// read return; mem_* memory port (1-cycle read latency); owner state;
// s_stall_cnt saturating search starvation count.
// Optional: ASTAR_ARB_STARVE_GUARD_EN lets search win after MAX_WAIT
// display grants while it pends.
module grid_mem_arbiter
  import astar_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              sync,
  input  logic              reset,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic [7:0]        s_stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  owner_e            state_q, state_d;
  logic [7:0]        stall_q, stall_d;
  logic [WAIT_W-1:0] wait_q;
  logic              s_rd_q, d_rd_q;
  logic [DATA_W-1:0] s_hold_q, d_hold_q;
  logic              force_s;
  logic              d_sel, s_sel;
  logic              d_win, s_win;

`ifdef ASTAR_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
  logic [WAIT_W-1:0] wait_d;

  always_comb begin
    wait_d = wait_q;
    if (s_win || !s_req)
      wait_d = '0;
    else if (d_win)
      wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge sync or posedge reset) begin
    if (reset)
      wait_q <= '0;
    else
      wait_q <= wait_d;
  end
`else
  localparam bit GUARD_EN = 1'b0;
  assign wait_q = '0;
`endif

  assign force_s = GUARD_EN && s_req &&
                   (wait_q == WAIT_W'(MAX_WAIT));

  // Mutually exclusive selects so the decoder is truly one-hot.
  assign d_sel = d_req && !force_s;
  assign s_sel = s_req && !d_sel;

  always_comb begin
    d_win   = 1'b0;
    s_win   = 1'b0;
    state_d = OWN_IDLE;
    if (!reset) begin
      unique case (1'b1)
        d_sel: begin
          d_win   = 1'b1;
          state_d = OWN_DISP;
        end
        s_sel: begin
          s_win   = 1'b1;
          state_d = OWN_SRCH;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (s_win)
      stall_d = '0;
    else if (s_req && stall_q != 8'hFF)
      stall_d = stall_q + 8'd1;
  end

  always_ff @(posedge sync or posedge reset) begin
    if (reset) begin
      state_q  <= OWN_IDLE;
      stall_q  <= '0;
      s_rd_q   <= 1'b0;
      d_rd_q   <= 1'b0;
      s_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      s_rd_q  <= s_win && !s_we;
      d_rd_q  <= d_win;
      if (s_rd_q)
        s_hold_q <= mem_rdata;
      if (d_rd_q)
        d_hold_q <= mem_rdata;
    end
  end

  assign s_gnt       = s_win;
  assign d_gnt       = d_win;
  assign mem_en      = s_win || d_win;
  assign mem_we      = s_win && s_we;
  assign mem_addr    = d_win ? d_addr :
                       s_win ? s_addr : '0;
  assign mem_wdata   = s_win ? s_wdata : '0;
  assign s_rvalid    = s_rd_q;
  assign d_rvalid    = d_rd_q;
  assign s_rdata     = s_rd_q ? mem_rdata : s_hold_q;
  assign d_rdata     = d_rd_q ? mem_rdata : d_hold_q;
  assign owner       = state_q;
  assign s_stall_cnt = stall_q;

endmodule
